// File: rtl/arp_pkg.sv
// arp_pkg: shared ARP constants and types.
//   ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IPV4 : fixed header field values
//   ARP_OPER_REQUEST / ARP_OPER_REPLY          : ARP operation codes
//   MAC_BCAST                                  : Ethernet broadcast address
//   arp_state_e                                : transmit scheduler FSM states
//   grant_e                                    : channel identifiers for arbitration
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam logic [47:0] MAC_BCAST        = 48'hFFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arp_state_e;

  typedef enum logic {
    GRANT_REPLY = 1'b0,
    GRANT_QUERY = 1'b1
  } grant_e;

endpackage

// File: rtl/arp_tx_sched.sv
// arp_tx_sched: schedules ARP reply and query requests into single ARP frames
// for a downstream frame transmitter. One frame is held at a time; a new
// request is only accepted once the held frame has been taken.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   local_mac, local_ip          : own addresses, captured into each frame
//   reply_req_*                  : reply request (requester MAC/IP), valid/ready
//   query_req_*                  : query request (IP to resolve), valid/ready
//   m_frame_valid/m_frame_ready  : frame handshake to the transmitter
//   m_eth_* / m_arp_*            : registered frame fields
//   busy                         : high while a frame is held (== m_frame_valid)
//
// Parameter QUERY_GAP: minimum cycles between accepted queries (0 = no holdoff).
// Build option: define ARP_TX_SCHED_RR_EN for round-robin arbitration between
// reply and query on contention; otherwise reply always wins.
module arp_tx_sched
  import arp_pkg::*;
#(
  parameter int QUERY_GAP = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic        reply_req_valid,
  output logic        reply_req_ready,
  input  logic [47:0] reply_req_mac,
  input  logic [31:0] reply_req_ip,
  input  logic        query_req_valid,
  output logic        query_req_ready,
  input  logic [31:0] query_req_ip,
  output logic        m_frame_valid,
  input  logic        m_frame_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [15:0] m_arp_htype,
  output logic [15:0] m_arp_ptype,
  output logic [15:0] m_arp_oper,
  output logic [47:0] m_arp_sha,
  output logic [31:0] m_arp_spa,
  output logic [47:0] m_arp_tha,
  output logic [31:0] m_arp_tpa,
  output logic        busy
);

  localparam int CNT_W = (QUERY_GAP > 0) ? $clog2(QUERY_GAP + 1) : 1;

  // The acceptance cycle itself counts as the first holdoff cycle, so the
  // counter reaches zero (query eligible again) exactly QUERY_GAP cycles
  // after an accepted query.
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (QUERY_GAP > 0) ? CNT_W'(QUERY_GAP - 1) : {CNT_W{1'b0}};

  arp_state_e       state_r;
  logic [CNT_W-1:0] holdoff_r;
  logic             query_cand_s;
  logic             grant_reply_s;
  logic             grant_query_s;

`ifdef ARP_TX_SCHED_RR_EN
  grant_e           last_grant_r;

  // Round-robin pointer: records which channel won the most recent acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= GRANT_REPLY;
    end else if (grant_reply_s) begin
      last_grant_r <= GRANT_REPLY;
    end else if (grant_query_s) begin
      last_grant_r <= GRANT_QUERY;
    end
  end
`endif

  // Grant decision: only possible in IDLE; contention resolved by the build policy.
  always_comb begin
    grant_reply_s = 1'b0;
    grant_query_s = 1'b0;
    query_cand_s  = query_req_valid && (holdoff_r == {CNT_W{1'b0}});
    if (state_r == IDLE) begin
      if (reply_req_valid && query_cand_s) begin
`ifdef ARP_TX_SCHED_RR_EN
        if (last_grant_r == GRANT_REPLY) begin
          grant_query_s = 1'b1;
        end else begin
          grant_reply_s = 1'b1;
        end
`else
        grant_reply_s = 1'b1;
`endif
      end else if (reply_req_valid) begin
        grant_reply_s = 1'b1;
      end else if (query_cand_s) begin
        grant_query_s = 1'b1;
      end else begin
        grant_reply_s = 1'b0;
        grant_query_s = 1'b0;
      end
    end else begin
      grant_reply_s = 1'b0;
      grant_query_s = 1'b0;
    end
  end

  // Readies are masked during reset so no upstream handshake can complete then.
  assign reply_req_ready = grant_reply_s & ~rst;
  assign query_req_ready = grant_query_s & ~rst;
  assign busy            = m_frame_valid;

  // Query holdoff counter: loaded on query acceptance, counts down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdoff_r <= {CNT_W{1'b0}};
    end else if (grant_query_s) begin
      holdoff_r <= GAP_LOAD;
    end else if (holdoff_r != {CNT_W{1'b0}}) begin
      holdoff_r <= holdoff_r - CNT_W'(1);
    end
  end

  // Frame FSM: capture all fields on acceptance and hold them until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      m_frame_valid  <= 1'b0;
      m_eth_dest_mac <= 48'h0;
      m_eth_src_mac  <= 48'h0;
      m_eth_type     <= 16'h0;
      m_arp_htype    <= 16'h0;
      m_arp_ptype    <= 16'h0;
      m_arp_oper     <= 16'h0;
      m_arp_sha      <= 48'h0;
      m_arp_spa      <= 32'h0;
      m_arp_tha      <= 48'h0;
      m_arp_tpa      <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_reply_s || grant_query_s) begin
            state_r       <= SEND;
            m_frame_valid <= 1'b1;
            m_eth_src_mac <= local_mac;
            m_arp_sha     <= local_mac;
            m_arp_spa     <= local_ip;
            m_eth_type    <= ETH_TYPE_ARP;
            m_arp_htype   <= ARP_HTYPE_ETH;
            m_arp_ptype   <= ARP_PTYPE_IPV4;
            if (grant_reply_s) begin
              m_eth_dest_mac <= reply_req_mac;
              m_arp_tha      <= reply_req_mac;
              m_arp_tpa      <= reply_req_ip;
              m_arp_oper     <= ARP_OPER_REPLY;
            end else begin
              m_eth_dest_mac <= MAC_BCAST;
              m_arp_tha      <= 48'h0;
              m_arp_tpa      <= query_req_ip;
              m_arp_oper     <= ARP_OPER_REQUEST;
            end
          end
        end
        SEND: begin
          // Completion cycle never overlaps an acceptance: back to IDLE first.
          if (m_frame_ready) begin
            state_r       <= IDLE;
            m_frame_valid <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          m_frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_tx_sched.sv
// tb_arp_tx_sched: self-checking bench for arp_tx_sched. Two instances share
// stimulus: index 0 has QUERY_GAP=0, index 1 has QUERY_GAP=10. A transaction
// level reference model (held frame, cycles since last query, last winner)
// predicts readies and fields every cycle; a vector table and directed
// sequences add fixed expectations.
module tb_arp_tx_sched;

  localparam logic [47:0] LMAC = 48'h0A1B_2C3D_4E5F;
  localparam logic [31:0] LIP  = 32'hC0A8_0001;
  localparam logic [47:0] MA   = 48'h0200_0000_0001;
  localparam logic [31:0] IA   = 32'h0A00_0005;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
  localparam int          SAT  = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rv = 1'b0, qv = 1'b0, rdy = 1'b0;
  logic [47:0] rmac = 48'h0;
  logic [31:0] rip = 32'h0, qip = 32'h0;

  logic        rr[2], qr[2], fv[2], bsy[2];
  logic [47:0] dmac[2], smac[2], sha[2], tha[2];
  logic [15:0] etype[2], htype[2], ptype[2], oper[2];
  logic [31:0] spa[2], tpa[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    arp_tx_sched #(.QUERY_GAP(g == 0 ? 0 : 10)) dut (
      .clk(clk), .rst(rst), .local_mac(LMAC), .local_ip(LIP),
      .reply_req_valid(rv), .reply_req_ready(rr[g]),
      .reply_req_mac(rmac), .reply_req_ip(rip),
      .query_req_valid(qv), .query_req_ready(qr[g]), .query_req_ip(qip),
      .m_frame_valid(fv[g]), .m_frame_ready(rdy),
      .m_eth_dest_mac(dmac[g]), .m_eth_src_mac(smac[g]), .m_eth_type(etype[g]),
      .m_arp_htype(htype[g]), .m_arp_ptype(ptype[g]), .m_arp_oper(oper[g]),
      .m_arp_sha(sha[g]), .m_arp_spa(spa[g]), .m_arp_tha(tha[g]),
      .m_arp_tpa(tpa[g]), .busy(bsy[g])
    );
  end

  int n_err = 0;
  int n_chk = 0;

  // reference model state
  int          gap[2] = '{0, 10};
  bit          held[2], loaded[2], last_q[2];
  int          since[2];
  logic [47:0] e_dest[2], e_tha[2];
  logic [31:0] e_tpa[2];
  logic [15:0] e_oper[2];
  bit          exp_rr[2], exp_qr[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      held[i] = 1'b0; loaded[i] = 1'b0; last_q[i] = 1'b0; since[i] = SAT;
      e_dest[i] = 48'h0; e_tha[i] = 48'h0; e_tpa[i] = 32'h0; e_oper[i] = 16'h0;
      exp_rr[i] = 1'b0; exp_qr[i] = 1'b0;
    end
  endtask

  // Predict readies from current inputs and compare every output.
  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      bit qe;
      bit reply_first;
      qe = (since[i] >= gap[i]);
`ifdef ARP_TX_SCHED_RR_EN
      reply_first = last_q[i];
`else
      reply_first = 1'b1;
`endif
      if (rst || held[i]) begin
        exp_rr[i] = 1'b0;
        exp_qr[i] = 1'b0;
      end else begin
        exp_rr[i] = rv && !(qv && qe && !reply_first);
        exp_qr[i] = qv && qe && !exp_rr[i];
      end
      chk($sformatf("d%0d.reply_ready", i), 64'(rr[i]), 64'(exp_rr[i]));
      chk($sformatf("d%0d.query_ready", i), 64'(qr[i]), 64'(exp_qr[i]));
      chk($sformatf("d%0d.valid", i), 64'(fv[i]), 64'(held[i]));
      chk($sformatf("d%0d.busy", i), 64'(bsy[i]), 64'(held[i]));
      chk($sformatf("d%0d.dest", i), 64'(dmac[i]), 64'(e_dest[i]));
      chk($sformatf("d%0d.tha", i), 64'(tha[i]), 64'(e_tha[i]));
      chk($sformatf("d%0d.tpa", i), 64'(tpa[i]), 64'(e_tpa[i]));
      chk($sformatf("d%0d.oper", i), 64'(oper[i]), 64'(e_oper[i]));
      chk($sformatf("d%0d.src", i), 64'(smac[i]), loaded[i] ? 64'(LMAC) : 64'h0);
      chk($sformatf("d%0d.sha", i), 64'(sha[i]), loaded[i] ? 64'(LMAC) : 64'h0);
      chk($sformatf("d%0d.spa", i), 64'(spa[i]), loaded[i] ? 64'(LIP) : 64'h0);
      chk($sformatf("d%0d.etype", i), 64'(etype[i]), loaded[i] ? 64'h0806 : 64'h0);
      chk($sformatf("d%0d.htype", i), 64'(htype[i]), loaded[i] ? 64'h0001 : 64'h0);
      chk($sformatf("d%0d.ptype", i), 64'(ptype[i]), loaded[i] ? 64'h0800 : 64'h0);
    end
  endtask

  // Advance the model across one clock edge using the predicted grants.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit qacc;
        qacc = 1'b0;
        if (held[i]) begin
          if (rdy) held[i] = 1'b0;
        end else if (exp_rr[i]) begin
          held[i] = 1'b1; loaded[i] = 1'b1; last_q[i] = 1'b0;
          e_dest[i] = rmac; e_tha[i] = rmac; e_tpa[i] = rip; e_oper[i] = 16'd2;
        end else if (exp_qr[i]) begin
          held[i] = 1'b1; loaded[i] = 1'b1; last_q[i] = 1'b1; qacc = 1'b1;
          e_dest[i] = BC; e_tha[i] = 48'h0; e_tpa[i] = qip; e_oper[i] = 16'd1;
        end
        if (qacc) since[i] = 1;
        else if (since[i] < SAT) since[i]++;
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  typedef struct {
    bit          rv, qv, rdy;
    logic [31:0] qip;
    bit          e_fv, e_rr, e_qr;
    logic [15:0] e_oper;
    logic [47:0] e_dest, e_tha;
    logic [31:0] e_tpa;
  } vec_t;

  vec_t vt[8];

  initial begin
    int tq[$];
    bit grants[$];
    int nrep;
    int alt;
    int nq;

    // --- reset, with both requests valid to see readies masked ---
    model_reset();
    rmac = MA; rip = IA; qip = 32'h0A00_0009;
    #2 rst = 1'b1; rv = 1'b1; qv = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst.d%0d.valid", i), 64'(fv[i]), 64'h0);
      chk($sformatf("rst.d%0d.busy", i), 64'(bsy[i]), 64'h0);
      chk($sformatf("rst.d%0d.readies", i), 64'({rr[i], qr[i]}), 64'h0);
      chk($sformatf("rst.d%0d.oper", i), 64'(oper[i]), 64'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; rv = 1'b0; qv = 1'b0;

    // --- vector table: reply, query, stall, holdoff-limited contention ---
    vt[0] = '{1, 0, 1, 32'h0,         0, 1, 0, 16'd0, 48'h0, 48'h0, 32'h0};
    vt[1] = '{0, 1, 1, 32'h0A00_0009, 1, 0, 0, 16'd2, MA,    MA,    IA};
    vt[2] = '{0, 1, 1, 32'h0A00_0009, 0, 0, 1, 16'd2, MA,    MA,    IA};
    vt[3] = '{0, 0, 0, 32'h0A00_0009, 1, 0, 0, 16'd1, BC,    48'h0, 32'h0A00_0009};
    vt[4] = '{1, 0, 0, 32'h0A00_0009, 1, 0, 0, 16'd1, BC,    48'h0, 32'h0A00_0009};
    vt[5] = '{1, 0, 1, 32'h0A00_0009, 1, 0, 0, 16'd1, BC,    48'h0, 32'h0A00_0009};
    vt[6] = '{1, 1, 1, 32'h0A00_0009, 0, 1, 0, 16'd1, BC,    48'h0, 32'h0A00_0009};
    vt[7] = '{0, 0, 1, 32'h0A00_0009, 1, 0, 0, 16'd2, MA,    MA,    IA};
    for (int k = 0; k < 8; k++) begin
      rv = vt[k].rv; qv = vt[k].qv; rdy = vt[k].rdy; qip = vt[k].qip;
      to_neg();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vec%0d.d%0d.valid", k, i), 64'(fv[i]), 64'(vt[k].e_fv));
        chk($sformatf("vec%0d.d%0d.rready", k, i), 64'(rr[i]), 64'(vt[k].e_rr));
        chk($sformatf("vec%0d.d%0d.qready", k, i), 64'(qr[i]), 64'(vt[k].e_qr));
        chk($sformatf("vec%0d.d%0d.oper", k, i), 64'(oper[i]), 64'(vt[k].e_oper));
        chk($sformatf("vec%0d.d%0d.dest", k, i), 64'(dmac[i]), 64'(vt[k].e_dest));
        chk($sformatf("vec%0d.d%0d.tha", k, i), 64'(tha[i]), 64'(vt[k].e_tha));
        chk($sformatf("vec%0d.d%0d.tpa", k, i), 64'(tpa[i]), 64'(vt[k].e_tpa));
      end
      to_pos();
    end

    // --- 5-cycle stall: fields stable even though request inputs change ---
    rv = 1'b1; qv = 1'b0; rdy = 1'b0; rmac = 48'h0200_0000_000A; rip = 32'h0A00_000A;
    cyc();
    for (int k = 0; k < 5; k++) begin
      rmac = 48'h0200_0000_00F0 + 48'(k); rip = 32'h0B00_0000 + 32'(k); qv = 1'b1;
      to_neg();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stall%0d.d%0d.busy", k, i), 64'(bsy[i]), 64'h1);
        chk($sformatf("stall%0d.d%0d.readies", k, i), 64'({rr[i], qr[i]}), 64'h0);
        chk($sformatf("stall%0d.d%0d.dest", k, i), 64'(dmac[i]), 64'h0200_0000_000A);
        chk($sformatf("stall%0d.d%0d.tpa", k, i), 64'(tpa[i]), 64'h0A00_000A);
      end
      to_pos();
    end
    rv = 1'b0; qv = 1'b0; rdy = 1'b1;
    cyc();

    // --- continuous contention on the gap-0 instance ---
    rv = 1'b1; qv = 1'b1; rdy = 1'b1; rmac = MA; rip = IA; qip = 32'h0A00_0009;
    for (int k = 0; k < 20; k++) begin
      to_neg();
      if (rr[0]) grants.push_back(1'b0);
      else if (qr[0]) grants.push_back(1'b1);
      to_pos();
    end
    chk("contend.grant_count", 64'(grants.size()), 64'd10);
    alt = 0; nq = 0;
    for (int k = 0; k < grants.size(); k++) begin
      if (grants[k]) nq++;
      if (k > 0 && grants[k] != grants[k-1]) alt++;
    end
`ifdef ARP_TX_SCHED_RR_EN
    chk("contend.alternation", 64'(alt), 64'(grants.size() - 1));
`else
    chk("contend.query_grants", 64'(nq), 64'd0);
`endif

    // --- query holdoff on the gap-10 instance, replies served in the gap ---
    rv = 1'b0; qv = 1'b0;
    for (int k = 0; k < 12; k++) cyc();
    qv = 1'b1; qip = 32'h0A00_000B; nrep = 0;
    for (int c = 0; c < 40 && tq.size() < 2; c++) begin
      to_neg();
      if (qr[1]) tq.push_back(c);
      if (rr[1] && tq.size() == 1) nrep++;
      to_pos();
      rv = (tq.size() == 1 && nrep < 4);
    end
    chk("gap.query_accepts", 64'(tq.size()), 64'd2);
    if (tq.size() == 2) chk("gap.distance", 64'(tq[1] - tq[0]), 64'd10);
    chk("gap.replies_in_gap", 64'(nrep), 64'd4);
    rv = 1'b0; qv = 1'b0;
    cyc();

    // --- asynchronous reset while a frame is held ---
    rv = 1'b1; rmac = 48'h0200_0000_000D; rip = 32'h0A00_000D; rdy = 1'b0;
    cyc();
    rv = 1'b0;
    cyc();
    #2 rst = 1'b1; rv = 1'b1; qv = 1'b1; qip = 32'h0A00_000C;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst.d%0d.valid", i), 64'(fv[i]), 64'h0);
      chk($sformatf("arst.d%0d.busy", i), 64'(bsy[i]), 64'h0);
      chk($sformatf("arst.d%0d.readies", i), 64'({rr[i], qr[i]}), 64'h0);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; rv = 1'b0; qv = 1'b1; rdy = 1'b1;
    to_neg();
    chk("arst.query_after_reset", 64'(qr[1]), 64'h1);
    to_pos();
    qv = 1'b0;
    to_neg();
    chk("arst.frame_valid", 64'(fv[1]), 64'h1);
    chk("arst.frame_tpa", 64'(tpa[1]), 64'h0A00_000C);
    chk("arst.frame_oper", 64'(oper[1]), 64'h1);
    to_pos();

    // --- randomized traffic against the model ---
    for (int k = 0; k < 300; k++) begin
      rv   = ($urandom_range(0, 2) == 0);
      qv   = ($urandom_range(0, 1) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      rmac = {16'($urandom()), $urandom()};
      rip  = $urandom();
      qip  = $urandom();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
